// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read-port bundle between a first-word-fall-through FIFO and its drain.
interface uart_tx_drain_if #(
  parameter int WIDTH = 8
);
  // fifo_data_in is valid whenever fifo_empty_in is low; a one-cycle
  // fifo_rd_out pulse pops the head at the next clock edge and is never
  // raised while fifo_empty_in is high.
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_empty_in;
  logic             fifo_rd_out;

  modport master (
    input  fifo_data_in,
    input  fifo_empty_in,
    output fifo_rd_out
  );

  modport slave (
    output fifo_data_in,
    output fifo_empty_in,
    input  fifo_rd_out
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit.
module uart_baud_tick #(
  parameter int DIV = 8
) (
  input  logic CLK,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else if (clear_in || tick_out) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick_out = (r_cnt == LAST);
endmodule

// File: rtl/uart_tx_drain.sv
// Drains a FWFT FIFO into seamless back-to-back UART frames (8N1 by default).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int WIDTH    = 8
) (
  input  logic            CLK,
  input  logic            rst_in,
  uart_tx_drain_if.master fifo,
  output logic            tx_out,
  output logic            busy_out,
  output uart_state_t     state_out
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_drain: clocks per bit must be at least 2");
  end

  uart_state_t      r_state, w_next;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_armed;
  logic             w_pop, w_tick, w_clear;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .CLK      (CLK),
    .rst_in   (rst_in),
    .clear_in (w_clear),
    .tick_out (w_tick)
  );

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo.fifo_empty_in && r_armed) begin
          w_pop  = 1'b1;
          w_next = START;
        end
      end
      START: if (w_tick) w_next = DATA;
      DATA: begin
        if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_next = STOP;
`endif
      STOP: begin
        if (w_tick) begin
          if (!fifo.fifo_empty_in) begin
            w_pop  = 1'b1;
            w_next = START;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Each state gets a fresh bit period; idle keeps the counter parked at zero.
  assign w_clear = (w_next != r_state) || (r_state == IDLE);

  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = '0;
    if (w_pop) begin
      w_shift_nxt = fifo.fifo_data_in;
    end else if ((r_state == DATA) && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end
    if (r_state == DATA) begin
      if (w_tick) begin
        w_bit_cnt_nxt = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt;
      end
    end
  end

  // The line is driven from a register, so it is computed from the next state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_next)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_par;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // r_armed holds off the first pop for one cycle after reset release.
  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_armed   <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^fifo.fifo_data_in;
    end
  end
`endif

  assign fifo.fifo_rd_out = w_pop;
  assign tx_out           = r_tx;
  assign busy_out         = (r_state != IDLE);
  assign state_out        = r_state;
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain at DIV=8 with a queue-backed FIFO and serial decoder.
module tb_uart_tx_drain;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 8;

  logic        CLK = 1'b0;
  logic        rst_in;
  logic        tx_out;
  logic        busy_out;
  uart_state_t state_out;

  uart_tx_drain_if #(.WIDTH(8)) ifc ();

  uart_tx_drain #(.CLK_FREQ(8), .BAUD(1), .WIDTH(8)) dut (
    .CLK       (CLK),
    .rst_in    (rst_in),
    .fifo      (ifc.master),
    .tx_out    (tx_out),
    .busy_out  (busy_out),
    .state_out (state_out)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pop_cnt = 0;
  int         pop_cyc[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       pend = 1'b0;
  event       push_ev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  // FIFO model: a pop seen mid-cycle is removed at the following negedge.
  always @(negedge CLK or push_ev) begin
    if (!CLK) begin
      if (ifc.fifo_rd_out) check_eq("pop_when_empty", ifc.fifo_empty_in, 0);
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend = 1'b0;
      if (ifc.fifo_rd_out) begin
        pend = 1'b1;
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
    end
    ifc.fifo_empty_in = (fifo_q.size() == 0);
    ifc.fifo_data_in  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_rx);
    fifo_q.push_back(b);
    if (expect_rx) exp_q.push_back(b);
    -> push_ev;
  endtask

  // Serial decoder sampling mid-bit; scoreboard against exp_q.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge CLK) begin
    if (rst_in) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx_out == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_busy) begin
      if (rx_cnt == 4) begin
        check_eq("rx_start", tx_out, 0);
      end else if (rx_cnt >= 12 && rx_cnt < 76 && (rx_cnt % 8) == 4) begin
        rx_byte = {tx_out, rx_byte[7:1]};
`ifdef UART_TX_PARITY_EN
      end else if (rx_cnt == 76) begin
        check_eq("rx_parity", tx_out, ^rx_byte);
`endif
      end else if (rx_cnt == FRAME - 4) begin
        check_eq("rx_stop", tx_out, 1);
        check_eq("rx_have_exp", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("rx_byte", rx_byte, exp_q.pop_front());
      end
      if (rx_cnt == FRAME - 1) rx_busy = 1'b0;
    end
  end

  task automatic watch_frame(input string tag, input logic [7:0] b, input logic [NB-1:0] bits);
    @(posedge CLK);
    #2;
    push_byte(b, 1'b1);
    @(negedge CLK);
    check_eq({tag, "_pop"}, ifc.fifo_rd_out, 1);
    check_eq({tag, "_busy_pre"}, busy_out, 0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      check_eq({tag, "_tx"}, tx_out, bits[i / 8]);
      check_eq({tag, "_busy"}, busy_out, 1);
      check_eq({tag, "_nopop"}, ifc.fifo_rd_out, 0);
    end
    @(negedge CLK);
    check_eq({tag, "_idle_tx"}, tx_out, 1);
    check_eq({tag, "_idle_busy"}, busy_out, 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy_out) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_eq({tag, "_drained"}, n < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_in = 1'b1;
    #1 -> push_ev;
    repeat (3) @(negedge CLK);
    check_eq("rst_tx", tx_out, 1);
    check_eq("rst_rd", ifc.fifo_rd_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_state", state_out, IDLE);
    rst_in = 1'b0;
    repeat (3) @(negedge CLK);

`ifdef UART_TX_PARITY_EN
    watch_frame("par07", 8'h07, 11'b11000001110);
    watch_frame("par03", 8'h03, 11'b10000000110);
`else
    watch_frame("a5", 8'hA5, 10'b1101001010);
`endif
    wait_drain("single", 50);

    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      check_eq("idle_line", {tx_out, busy_out, ifc.fifo_rd_out}, 3'b100);
    end

    base = pop_cnt;
    @(posedge CLK);
    #2;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    wait_drain("three", 4 * FRAME);
    check_eq("three_pops", pop_cnt - base, 3);
    if (pop_cnt - base >= 3) begin
      check_eq("three_gap01", pop_cyc[base + 1] - pop_cyc[base], FRAME);
      check_eq("three_gap12", pop_cyc[base + 2] - pop_cyc[base + 1], FRAME);
    end

    @(posedge CLK);
    #2;
    push_byte(8'h3C, 1'b0);
    push_byte(8'h81, 1'b1);
    @(negedge CLK);
    check_eq("rst_pop3c", ifc.fifo_rd_out, 1);
    repeat (36) @(negedge CLK);
    rst_in = 1'b1;
    #1;
    check_eq("midrst_tx", tx_out, 1);
    check_eq("midrst_busy", busy_out, 0);
    check_eq("midrst_state", state_out, IDLE);
    repeat (3) @(negedge CLK);
    check_eq("midrst_nopop", ifc.fifo_rd_out, 0);
    rst_in = 1'b0;
    n = 0;
    while (tx_out && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check_eq("rst_restart", tx_out, 0);
    check_eq("rst_gap_ge2", n >= 2, 1);
    wait_drain("rst", 2 * FRAME);

    base = pop_cnt;
    @(posedge CLK);
    #2;
    for (int i = 0; i < 15; i++) push_byte(8'(8'h5A + i), 1'b1);
    wait_drain("full", 16 * FRAME);
    check_eq("full_pops", pop_cnt - base, 15);
    check_eq("full_left", fifo_q.size(), 0);

    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmitter that drains bytes from the upstream `fifo` and sends them as 8N1 UART frames on the icebreaker TX pin. It sits directly downstream of the FIFO's first-word-fall-through read port: it samples `dataout`/`empty_out` and drives `rd_in`. Back-to-back frames are seamless while the FIFO holds data, and the line idles high otherwise.

## Interface
- `CLK_FREQ`, 12000000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s; `DIV = (CLK_FREQ + BAUD/2) / BAUD` clocks per bit (104 at defaults); `DIV >= 2` is an elaboration error otherwise
- `WIDTH`, 8, data bits per frame; must match the FIFO `WIDTH`
- `CLK`  input  1  system clock, rising edge
- `rst_in`  input  1  reset, asynchronous, active-high
- `fifo_data_in`  input  WIDTH  FIFO head word; valid combinationally whenever `fifo_empty_in` is low
- `fifo_empty_in`  input  1  FIFO empty flag
- `fifo_rd_out`  output  1  pop strobe to FIFO `rd_in`; single-cycle pulse
- `tx_out`  output  1  serial line, registered, idle high
- `busy_out`  output  1  high while a frame is on the line

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Bit counter `bit_cnt` is `$clog2(WIDTH)` wide. Baud counter `baud_cnt` is `$clog2(DIV)` wide; it counts 0..DIV-1, and `tick` = (`baud_cnt == DIV-1`).
- IDLE, `fifo_empty_in`=0:
  - latch `fifo_data_in` into the shift register
  - assert `fifo_rd_out` for this cycle only
  - clear `baud_cnt`
  - go to START
- IDLE, `fifo_empty_in`=1: stay in IDLE, `tx_out`=1.
- START: `tx_out`=0. On `tick`, go to DATA with `bit_cnt`=0.
- DATA: `tx_out` = shift register bit 0, LSB first. On `tick`, shift right and increment `bit_cnt`. After bit WIDTH-1, go to PARITY if enabled, otherwise STOP.
- STOP: `tx_out`=1. On `tick`:
  - FIFO non-empty: pop and latch as in IDLE, then go straight to START (no idle gap).
  - FIFO empty: go to IDLE.
- `baud_cnt` resets to 0 on every state transition.
- The word is captured at pop time. Later FIFO changes, or the FIFO going empty mid-frame, do not affect the frame in flight.
- `fifo_rd_out` is never asserted while `fifo_empty_in`=1. At most one pop occurs per frame.
- `busy_out` = (state != IDLE).

## Timing
- Reset values: `tx_out`=1, `fifo_rd_out`=0, `busy_out`=0, state IDLE, both counters 0, shift register 0.
- Pop in cycle T (combinational off registered state and `fifo_empty_in`). The start bit appears on `tx_out` at T+1.
- Each bit lasts exactly DIV clocks.
- Frame length is (WIDTH+2)·DIV clocks, or (WIDTH+3)·DIV with parity.
- Back-to-back: the next start bit begins on the clock directly after the last stop-bit clock.
- Reset asserted mid-frame: `tx_out` goes to 1 immediately (asynchronous). The popped word is lost. No pop occurs on the first cycle after release; the earliest pop is one cycle later, in IDLE.
- Latency from a non-empty FIFO while idle to the start bit is 1 clock.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state of DIV clocks is inserted between DATA and STOP. `tx_out` = even parity, i.e. the XOR of the WIDTH data bits.
- Undefined: there is no PARITY state and frames are 8N1.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP)
  - function `uart_div(clk_freq, baud)` returning the rounded divider
- Sub-module `uart_baud_tick`:
  - counter with `clear_in` and `tick_out`
  - parameter DIV
  - CLK and `rst_in`, same semantics as this block
- The FSM, shift register and parity live in `uart_tx_drain`.

## Test plan
- Bench parameters: CLK_FREQ=8, BAUD=1, so DIV=8. Parity off unless stated.
- Single byte 0xA5 written to an empty FIFO -> one `fifo_rd_out` pulse. `tx_out` = 0,1,0,1,0,0,1,0,1,1 with each bit held 8 clocks. `busy_out` is high for 80 clocks, then `fifo_empty_in`=1 and the line stays high.
- Three bytes 0x00, 0xFF, 0x55 preloaded -> three pops spaced exactly 80 clocks apart. There is no idle clock between frames, and the decoded stream is 0x00, 0xFF, 0x55.
- FIFO empty for 200 clocks -> `tx_out`=1, `busy_out`=0 and `fifo_rd_out`=0 throughout.
- `rst_in` pulsed at clock 35 of a 0x3C frame -> `tx_out`=1 the same cycle. The next queued byte 0x81 starts transmission no earlier than 2 clocks after release, as a complete frame.
- With `UART_TX_PARITY_EN`, send 0x07 -> parity bit 1 and a frame of 88 clocks. Send 0x03 -> parity bit 0.
- Full FIFO of 15 words of 0x5A to 0x68 -> exactly 15 pops, no pop while `fifo_empty_in`=1, and the words are received in order.
